hwag_coil_sched: RTL and testbench
==================================

Name: hwag_coil_sched

Overview:
- Multi-channel ignition coil scheduler directly downstream of the angle generator.
- Consumes the generator's fine angle counter (0..HWAMAXACR, 3840 steps per revolution) and its start/sync flag.
- Drives one coil output per channel between a programmable set angle (dwell start) and reset angle (spark).
- Angles are double-buffered and committed at the angle wrap; a dwell-time limit protects coils when the engine stalls.

Parameters:
ANGLE_WIDTH, 24, width of angle input and angle registers
CH_NUM, 4, number of coil channels (1..8)
DWELL_WIDTH, 16, width of max-dwell timer in clk ticks
MAX_ANGLE, 3839, last valid angle value (wrap point)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
sync  in  1  generator synchronised (hwag_start); low forces all channels off
angle  in  ANGLE_WIDTH  current angle from the generator's second angle counter
cfg_we  in  1  one-cycle write strobe for the shadow registers
cfg_ch  in  $clog2(CH_NUM) (min 1)  target channel
cfg_sel  in  1  0 = set angle, 1 = reset angle
cfg_data  in  ANGLE_WIDTH  angle value to write
max_dwell  in  DWELL_WIDTH  dwell limit in clk ticks; 0 disables the limit
coil_out  out  CH_NUM  coil drive, 1 = charging
dwell_fault  out  CH_NUM  sticky per-channel dwell-timeout flag
cfg_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset values: all outputs 0. Shadow and active set/reset registers are 0. Every channel FSM is in OFF.
- Config write:
  - On cfg_we with cfg_data <= MAX_ANGLE and cfg_ch < CH_NUM, update the selected shadow register at the next clk edge.
  - Otherwise drop the write and pulse cfg_err high for exactly 1 cycle.
- Commit:
  - angle_q is a register of angle. wrap = (angle == 0) & (angle_q != 0).
  - On wrap, all active registers load from the shadow registers in the same edge.
  - On wrap, dwell_fault bits clear.
  - A cfg_we coinciding with wrap writes the shadow only; the new value is committed at the next wrap.
  - While sync is low, active registers track the shadow registers every cycle.
- Per-channel FSM (states OFF, ARMED, CHARGE, BLANK):
  - OFF: coil 0. Go to ARMED when sync = 1.
  - ARMED: coil 0. If angle == set_act and set_act != reset_act, go to CHARGE; coil_out rises on the next edge (1-cycle latency from the match). The dwell timer clears.
  - CHARGE: coil 1. The dwell timer increments each clk and saturates at all-ones.
    - If angle == reset_act, go to ARMED and coil falls on the next edge.
    - Else if max_dwell != 0 and timer == max_dwell - 1, go to BLANK, coil falls, and set dwell_fault.
  - BLANK: coil 0. Go to ARMED on angle == reset_act or on wrap. This prevents re-arming while the angle is frozen.
  - Any state: sync = 0 forces OFF with coil 0 on the next edge. This overrides all other transitions.
  - Asynchronous rst forces OFF immediately, mid-charge included.
- Edge cases:
  - set_act == reset_act: the channel never charges.
  - A set/reset window spanning the wrap (set > reset) is legal. Charging continues across the wrap because the active reset value is compared after the commit.
  - A simultaneous set match and reset match is impossible because set != reset is required to enter CHARGE.
  - Equality matches use full ANGLE_WIDTH. Upper bits above the MAX_ANGLE range are compared as-is.

Decomposition:
- Shared package hwag_pkg holds:
  - localparam HWA_ANGLE_W = 24 and HWA_MAX_ACR = 3839;
  - typedef coil_state_t enum {OFF, ARMED, CHARGE, BLANK}.
- Top level holds the shadow registers, the commit/wrap logic and cfg_err.
- One sub-module hwag_coil_ch is instantiated CH_NUM times. It contains the FSM, dwell timer, active registers, coil_out bit and fault bit.

Test Plan:
- Reset and sync: hold rst = 0, then release with sync = 0 -> coil_out = 0 and dwell_fault = 0. Raise sync -> still 0 until a set match.
- Basic window: ch0 set = 32, reset = 96, committed by a wrap. Step angle 0..3839 -> coil_out[0] rises 1 clk after angle = 32 and falls 1 clk after angle = 96; other channels stay 0.
- Double buffer: write ch0 set = 200 while angle = 50 -> the window stays 32..96 this revolution and becomes 200..96 (spans the wrap) after the next wrap. The coil stays high through the wrap until angle = 96.
- Dwell limit: max_dwell = 100, ch1 set = 10, reset = 20, angle frozen at 15 -> coil_out[1] high for exactly 100 clk, then dwell_fault[1] = 1. The coil does not re-rise until angle = 20 or a wrap; the fault clears at the wrap.
- Bad config: cfg_data = 3840 and, with CH_NUM = 3, cfg_ch = 3 -> cfg_err pulses 1 cycle each time and the shadow registers are unchanged.
- Sync loss mid-charge: drop sync while coil_out[0] = 1 -> coil_out[0] = 0 on the next edge. With sync restored and angle already past 32, no charge occurs until the next set match.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG coil scheduler.
// Angle range matches the generator's fine angle counter.
package hwag_pkg;

   localparam int HWA_ANGLE_W = 24;
   localparam int HWA_MAX_ACR = 3839;

   typedef enum logic [1:0] {
      OFF,
      ARMED,
      CHARGE,
      BLANK
   } coil_state_t;

endpackage

// File: rtl/hwag_coil_sched_if.sv
// Configuration bus for the coil scheduler shadow registers.
interface hwag_coil_sched_if #(
   parameter int ANGLE_WIDTH = 24,
   parameter int CH_W        = 2
);

   logic                   cfg_we;
   logic [CH_W-1:0]        cfg_ch;
   logic                   cfg_sel;
   logic [ANGLE_WIDTH-1:0] cfg_data;
   logic                   cfg_err;

   modport master (
      output cfg_we,
      output cfg_ch,
      output cfg_sel,
      output cfg_data,
      input  cfg_err
   );

   modport slave (
      input  cfg_we,
      input  cfg_ch,
      input  cfg_sel,
      input  cfg_data,
      output cfg_err
   );

endinterface

// File: rtl/hwag_coil_ch.sv
// One coil channel: active angles, charge FSM, dwell timer
// and sticky dwell fault.
module hwag_coil_ch
   import hwag_pkg::*;
#(
   parameter int ANGLE_WIDTH = HWA_ANGLE_W,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sync,
   input  logic                   wrap,
   input  logic                   load,
   input  logic [ANGLE_WIDTH-1:0] angle,
   input  logic [ANGLE_WIDTH-1:0] set_sh,
   input  logic [ANGLE_WIDTH-1:0] rst_sh,
   input  logic [DWELL_WIDTH-1:0] max_dwell,
   output logic                   coil,
   output logic                   fault
);

   coil_state_t state, state_nx;

   logic [ANGLE_WIDTH-1:0] set_act;
   logic [ANGLE_WIDTH-1:0] rst_act;
   logic [DWELL_WIDTH-1:0] timer;
   logic                   set_hit;
   logic                   rst_hit;
   logic                   dwell_end;

   assign set_hit   = (angle == set_act) && (set_act != rst_act);
   assign rst_hit   = (angle == rst_act);
   assign dwell_end = (max_dwell != '0) &&
                      (timer == max_dwell - DWELL_WIDTH'(1));

   always_comb begin
      state_nx = state;
      unique case (state)
         OFF:    if (sync) state_nx = ARMED;
         ARMED:  if (set_hit) state_nx = CHARGE;
         CHARGE: begin
            if (rst_hit)        state_nx = ARMED;
            else if (dwell_end) state_nx = BLANK;
         end
         BLANK:  if (rst_hit || wrap) state_nx = ARMED;
      endcase
      // losing sync beats every other transition
      if (!sync) state_nx = OFF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= OFF;
         set_act <= '0;
         rst_act <= '0;
         timer   <= '0;
         fault   <= 1'b0;
      end else begin
         state <= state_nx;
         if (load) begin
            set_act <= set_sh;
            rst_act <= rst_sh;
         end
         if (state == ARMED && state_nx == CHARGE)
            timer <= '0;
         else if (state == CHARGE && timer != '1)
            timer <= timer + DWELL_WIDTH'(1);
         if (state == CHARGE && state_nx == BLANK)
            fault <= 1'b1;
         else if (wrap)
            fault <= 1'b0;
      end
   end

   assign coil = (state == CHARGE);

endmodule

// File: rtl/hwag_coil_sched.sv
// Multi-channel ignition coil scheduler: shadow angle registers,
// wrap-aligned commit and per-channel coil drivers.
module hwag_coil_sched
   import hwag_pkg::*;
#(
   parameter int ANGLE_WIDTH = HWA_ANGLE_W,
   parameter int CH_NUM      = 4,
   parameter int DWELL_WIDTH = 16,
   parameter int MAX_ANGLE   = HWA_MAX_ACR
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sync,
   input  logic [ANGLE_WIDTH-1:0] angle,
   input  logic [DWELL_WIDTH-1:0] max_dwell,
   hwag_coil_sched_if.slave       cfg,
   output logic [CH_NUM-1:0]      coil_out,
   output logic [CH_NUM-1:0]      dwell_fault
);

   localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic [ANGLE_WIDTH-1:0] set_sh [CH_NUM];
   logic [ANGLE_WIDTH-1:0] rst_sh [CH_NUM];
   logic [ANGLE_WIDTH-1:0] angle_q;
   logic                   cfg_ok;
   logic                   cfg_err_q;
   logic                   wrap;
   logic                   load;

   assign cfg_ok = (cfg.cfg_data <= ANGLE_WIDTH'(MAX_ANGLE)) &&
                   (32'(cfg.cfg_ch) < CH_NUM);
   assign wrap   = (angle == '0) && (angle_q != '0);
   // unsynchronised: active angles follow the shadow every cycle
   assign load   = wrap || !sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < CH_NUM; i++) begin
            set_sh[i] <= '0;
            rst_sh[i] <= '0;
         end
         angle_q   <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         angle_q   <= angle;
         cfg_err_q <= cfg.cfg_we && !cfg_ok;
         for (int i = 0; i < CH_NUM; i++) begin
            if (cfg.cfg_we && cfg_ok && cfg.cfg_ch == CH_W'(i)) begin
               if (cfg.cfg_sel) rst_sh[i] <= cfg.cfg_data;
               else             set_sh[i] <= cfg.cfg_data;
            end
         end
      end
   end

   assign cfg.cfg_err = cfg_err_q;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      hwag_coil_ch #(
         .ANGLE_WIDTH (ANGLE_WIDTH),
         .DWELL_WIDTH (DWELL_WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .sync      (sync),
         .wrap      (wrap),
         .load      (load),
         .angle     (angle),
         .set_sh    (set_sh[g]),
         .rst_sh    (rst_sh[g]),
         .max_dwell (max_dwell),
         .coil      (coil_out[g]),
         .fault     (dwell_fault[g])
      );
   end

endmodule

// File: tb/tb_hwag_coil_sched.sv
// Directed bench for hwag_coil_sched with three channels.
module tb_hwag_coil_sched;

   localparam int AW  = 24;
   localparam int CHN = 3;
   localparam int DW  = 16;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           sync;
   logic [AW-1:0]  angle;
   logic [DW-1:0]  max_dwell;
   logic [CHN-1:0] coil_out;
   logic [CHN-1:0] dwell_fault;

   int total  = 0;
   int passed = 0;
   int hi;

   hwag_coil_sched_if #(.ANGLE_WIDTH(AW), .CH_W(CW)) cfg ();

   hwag_coil_sched #(
      .ANGLE_WIDTH (AW),
      .CH_NUM      (CHN),
      .DWELL_WIDTH (DW),
      .MAX_ANGLE   (3839)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sync        (sync),
      .angle       (angle),
      .max_dwell   (max_dwell),
      .cfg         (cfg),
      .coil_out    (coil_out),
      .dwell_fault (dwell_fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
   endtask

   task automatic wr(input logic [CW-1:0] ch,
                     input logic sel,
                     input logic [AW-1:0] d);
      cfg.cfg_we   = 1'b1;
      cfg.cfg_ch   = ch;
      cfg.cfg_sel  = sel;
      cfg.cfg_data = d;
      step();
      cfg.cfg_we   = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      sync         = 1'b0;
      angle        = '0;
      max_dwell    = '0;
      cfg.cfg_we   = 1'b0;
      cfg.cfg_ch   = '0;
      cfg.cfg_sel  = 1'b0;
      cfg.cfg_data = '0;
      repeat (3) step();
      chk("rst_coil", 32'(coil_out), 0);
      chk("rst_fault", 32'(dwell_fault), 0);
      chk("rst_err", 32'(cfg.cfg_err), 0);

      rst = 1'b1;
      step();
      chk("nosync_coil", 32'(coil_out), 0);

      wr(0, 1'b0, 32);
      chk("wr_ok", 32'(cfg.cfg_err), 0);
      wr(0, 1'b1, 96);
      step();
      angle = 3839;
      sync  = 1'b1;
      step();
      chk("sync_coil", 32'(coil_out), 0);

      // rev 1: window 32..96, new set angle written mid-revolution
      for (int a = 0; a < 3840; a++) begin
         angle = AW'(a);
         if (a == 50) begin
            cfg.cfg_we   = 1'b1;
            cfg.cfg_ch   = '0;
            cfg.cfg_sel  = 1'b0;
            cfg.cfg_data = 200;
         end
         step();
         cfg.cfg_we = 1'b0;
         chk("rev1", 32'(coil_out), (a >= 32 && a <= 95) ? 1 : 0);
      end
      for (int a = 0; a < 3840; a++) begin
         angle = AW'(a);
         step();
         chk("rev2", 32'(coil_out), (a >= 200) ? 1 : 0);
      end
      for (int a = 0; a <= 120; a++) begin
         angle = AW'(a);
         step();
         chk("rev3", 32'(coil_out), (a <= 95) ? 1 : 0);
      end

      max_dwell = 100;
      wr(1, 1'b0, 10);
      wr(1, 1'b1, 20);
      angle = 0;
      step();
      chk("dw_commit", 32'(coil_out[1]), 0);
      angle = 10;
      step();
      chk("dw_rise", 32'(coil_out[1]), 1);
      hi    = 1;
      angle = 15;
      for (int i = 0; i < 110; i++) begin
         step();
         if (coil_out[1]) hi++;
      end
      chk("dw_len", 32'(hi), 100);
      chk("dw_fault", 32'(dwell_fault), 2);
      chk("dw_blank", 32'(coil_out[1]), 0);
      angle = 0;
      step();
      chk("dw_clr", 32'(dwell_fault), 0);
      chk("dw_wrap_off", 32'(coil_out[1]), 0);
      angle = 10;
      step();
      chk("dw_rearm", 32'(coil_out[1]), 1);
      max_dwell = 0;
      angle     = 20;
      step();
      chk("dw_fall", 32'(coil_out[1]), 0);

      wr(0, 1'b0, 3840);
      chk("bad_ang", 32'(cfg.cfg_err), 1);
      step();
      chk("bad_ang_end", 32'(cfg.cfg_err), 0);
      wr(3, 1'b0, 5);
      chk("bad_ch", 32'(cfg.cfg_err), 1);
      step();
      chk("bad_ch_end", 32'(cfg.cfg_err), 0);
      wr(2, 1'b0, 3839);
      chk("max_ok", 32'(cfg.cfg_err), 0);

      angle = 199;
      step();
      chk("sl_pre", 32'(coil_out[0]), 0);
      angle = 200;
      step();
      chk("sl_rise", 32'(coil_out[0]), 1);
      sync  = 1'b0;
      angle = 201;
      step();
      chk("sl_drop", 32'(coil_out[0]), 0);
      sync  = 1'b1;
      angle = 202;
      step();
      chk("sl_rearm", 32'(coil_out[0]), 0);
      for (int a = 203; a <= 210; a++) begin
         angle = AW'(a);
         step();
      end
      chk("sl_past", 32'(coil_out[0]), 0);
      angle = 200;
      step();
      chk("sl_match", 32'(coil_out[0]), 1);

      rst = 1'b0;
      #1;
      chk("async_rst", 32'(coil_out), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
